// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared configuration for the IF->ID sequencing controller: state encodings,
// parameter defaults and the state-transition rule.
package fetch_seq_ctrl_pkg;

    localparam int NSTAGE_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_state_e;

    // A redirect beats everything; FLUSH always falls back to RUN after one cycle.
    function automatic fsm_state_e fsm_next(input fsm_state_e cur,
                                            input logic       redirect,
                                            input logic       stall_req);
        fsm_state_e nxt;
        nxt = ST_RUN;
        if (redirect) begin
            nxt = ST_FLUSH;
        end else begin
            case (cur)
                ST_RUN, ST_HOLD: nxt = stall_req ? ST_HOLD : ST_RUN;
                ST_FLUSH:        nxt = ST_RUN;
                default:         nxt = ST_RUN;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_sat_counter.sv
// Saturating event counter used for the stall and flush statistics.
module sat_counter
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         INC,
    output logic [W-1:0] CNT
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: sticks at all ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (INC && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Stall/flush sequencer for the pipeline registers between fetch and decode,
// with a valid-tracking shadow of the stages and saturating event counters.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ID_STALL_REQ,
    input  logic              ICACHE_MISS,
    input  logic              MISPREDICT,
    input  logic [31:0]       MISPREDICT_PC,
    output logic [NSTAGE-1:0] STAGE_STALL,
    output logic [NSTAGE-1:0] STAGE_BUBBLE,
    output logic              IF_STALL,
    output logic              IF_REDIRECT,
    output logic [31:0]       IF_REDIRECT_PC,
    output logic              ID_VALID,
    output logic [1:0]        STATE,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    fsm_state_e        state_q;
    fsm_state_e        state_d;
    logic [NSTAGE-1:0] vld_q;
    logic [NSTAGE-1:0] vld_d;
    logic [31:0]       rpc_q;
    logic [31:0]       rpc_d;

    // Per-stage controls; stalls act in the same cycle the request arrives.
    always_comb begin
        STAGE_STALL  = '0;
        STAGE_BUBBLE = '0;
        IF_STALL     = 1'b0;
        IF_REDIRECT  = 1'b0;
        if (!RESET) begin
            STAGE_BUBBLE = '1;
            IF_STALL     = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            STAGE_BUBBLE = '1;
            IF_REDIRECT  = 1'b1;
        end else if (ID_STALL_REQ) begin
            STAGE_STALL  = '1;
            IF_STALL     = 1'b1;
        end else begin
            STAGE_BUBBLE[0] = ICACHE_MISS;
        end
    end

    // Next state, redirect target and stage-valid shadow.
    // Everything younger than a mispredicting branch is wrong-path, so the
    // valid shadow is dropped on the mispredict edge as well as in FLUSH.
    always_comb begin
        state_d = fsm_next(state_q, MISPREDICT, ID_STALL_REQ);
        rpc_d   = MISPREDICT ? MISPREDICT_PC : rpc_q;
        vld_d   = vld_q;
        if ((state_q == ST_FLUSH) || MISPREDICT) begin
            vld_d = '0;
        end else if (ID_STALL_REQ) begin
            vld_d = vld_q;
        end else begin
            for (int i = NSTAGE - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
            end
            vld_d[0] = ~ICACHE_MISS;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_RUN;
            vld_q   <= '0;
            rpc_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            rpc_q   <= rpc_d;
        end
    end

    assign STATE          = state_q;
    assign IF_REDIRECT_PC = rpc_q;
    assign ID_VALID       = RESET & vld_q[NSTAGE-1];

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (|STAGE_STALL),
        .CNT   (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (RESET & MISPREDICT),
        .CNT   (FLUSH_CNT)
    );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios plus random traffic against a
// queue-based pipeline model; a narrow-counter deep instance covers saturation.
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall_req;
    logic        miss;
    logic        mp;
    logic [31:0] mp_pc;

    logic [2:0]  stage_stall, stage_bubble;
    logic        if_stall, if_redirect, id_valid;
    logic [31:0] if_rpc;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic [7:0]  s_stall, s_bub;
    logic        s_ifs, s_red, s_idv;
    logic [31:0] s_rpc;
    logic [1:0]  s_state;
    logic [2:0]  s_scnt, s_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_state;
    bit          q3[$];
    bit          q8[$];
    logic [31:0] m_pc;
    int          m_stall_ev, m_flush_ev;
    logic [2:0]  e_stall, e_bub;
    logic [7:0]  e_stall8, e_bub8;
    logic        e_ifs, e_red, e_idv3, e_idv8;

    fetch_seq_ctrl dut (
        .CLK(clk), .RESET(rst_n), .ID_STALL_REQ(stall_req), .ICACHE_MISS(miss),
        .MISPREDICT(mp), .MISPREDICT_PC(mp_pc), .STAGE_STALL(stage_stall),
        .STAGE_BUBBLE(stage_bubble), .IF_STALL(if_stall), .IF_REDIRECT(if_redirect),
        .IF_REDIRECT_PC(if_rpc), .ID_VALID(id_valid), .STATE(state),
        .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    fetch_seq_ctrl #(.NSTAGE(8), .CNT_W(3)) dut_s (
        .CLK(clk), .RESET(rst_n), .ID_STALL_REQ(stall_req), .ICACHE_MISS(miss),
        .MISPREDICT(mp), .MISPREDICT_PC(mp_pc), .STAGE_STALL(s_stall),
        .STAGE_BUBBLE(s_bub), .IF_STALL(s_ifs), .IF_REDIRECT(s_red),
        .IF_REDIRECT_PC(s_rpc), .ID_VALID(s_idv), .STATE(s_state),
        .STALL_CNT(s_scnt), .FLUSH_CNT(s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int ev, input int mx);
        return (ev > mx) ? mx : ev;
    endfunction

    task automatic clear_pipes();
        q3 = {};
        q8 = {};
        for (int i = 0; i < 3; i++) q3.push_back(1'b0);
        for (int i = 0; i < 8; i++) q8.push_back(1'b0);
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        bit stalled;
        if (!rst_n) begin
            m_state = 0; m_pc = 32'h0; m_stall_ev = 0; m_flush_ev = 0;
            clear_pipes();
        end else begin
            stalled = (m_state != 2) && stall_req;
            if (stalled) m_stall_ev++;
            if (mp) begin
                m_flush_ev++;
                m_pc = mp_pc;
            end
            if (mp || m_state == 2) begin
                clear_pipes();
            end else if (!stalled) begin
                q3.push_front(bit'(~miss)); void'(q3.pop_back());
                q8.push_front(bit'(~miss)); void'(q8.pop_back());
            end
            m_state = mp ? 2 : (m_state == 2) ? 0 : (stall_req ? 1 : 0);
        end
    endtask

    // Expected combinational outputs for the current model state and inputs.
    task automatic model_comb();
        e_red = 1'b0; e_ifs = 1'b0; e_stall = 3'b000; e_bub = 3'b000;
        if (!rst_n) begin
            e_bub = 3'b111; e_ifs = 1'b1;
        end else if (m_state == 2) begin
            e_red = 1'b1; e_bub = 3'b111;
        end else if (stall_req) begin
            e_stall = 3'b111; e_ifs = 1'b1;
        end else begin
            e_bub = {2'b00, miss};
        end
        e_stall8 = {8{e_stall[0]}};
        e_bub8   = (e_bub == 3'b111) ? 8'hFF : {7'b0000000, e_bub[0]};
        e_idv3   = rst_n && q3[2];
        e_idv8   = rst_n && q8[7];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_req = 1'b1; miss = 1'b1; mp = 1'b1; mp_pc = 32'hDEAD_BEEF;
        clear_pipes(); m_state = 0;
        tick(); tick();
        @(negedge clk);
        n_checks++; if (stage_stall !== 3'b000) begin n_fail++; $display("FAIL rst_stall got=%b exp=000", stage_stall); end
        n_checks++; if (stage_bubble !== 3'b111) begin n_fail++; $display("FAIL rst_bubble got=%b exp=111", stage_bubble); end
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL rst_if_stall got=%b exp=1", if_stall); end
        n_checks++; if (if_redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect got=%b exp=0", if_redirect); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_checks++; if (if_rpc !== 32'h0) begin n_fail++; $display("FAIL rst_rpc got=%h exp=0", if_rpc); end
        n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_idle_fill();
        rst_n = 1'b1; stall_req = 1'b0; miss = 1'b0; mp = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            @(negedge clk);
            n_checks++; if (id_valid !== (k >= 3)) begin n_fail++; $display("FAIL fill_id_valid edge=%0d got=%b exp=%b", k, id_valid, (k >= 3)); end
            n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL fill_state got=%0d exp=0", state); end
        end
    endtask

    task automatic test_mispredict();
        mp = 1'b1; mp_pc = 32'h0040_0100;
        tick();
        mp = 1'b0; mp_pc = 32'h0;
        @(negedge clk);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL mp_state got=%0d exp=2", state); end
        n_checks++; if (if_redirect !== 1'b1 || if_stall !== 1'b0) begin n_fail++; $display("FAIL mp_if got=%b%b exp=10", if_redirect, if_stall); end
        n_checks++; if (if_rpc !== 32'h0040_0100) begin n_fail++; $display("FAIL mp_rpc got=%h exp=00400100", if_rpc); end
        n_checks++; if (stage_bubble !== 3'b111 || stage_stall !== 3'b000) begin n_fail++; $display("FAIL mp_stage got=%b/%b exp=111/000", stage_bubble, stage_stall); end
        n_checks++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL mp_flush_cnt got=%0d exp=1", flush_cnt); end
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                tick();
                @(negedge clk);
            end
            n_checks++; if (id_valid !== (c >= 4)) begin n_fail++; $display("FAIL mp_id_valid cyc=%0d got=%b exp=%b", c, id_valid, (c >= 4)); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) tick();
        stall_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            miss = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++; if (stage_stall !== 3'b111 || if_stall !== 1'b1) begin n_fail++; $display("FAIL stall_ctl got=%b/%b exp=111/1", stage_stall, if_stall); end
            n_checks++; if (stage_bubble !== 3'b000) begin n_fail++; $display("FAIL stall_bubble got=%b exp=000", stage_bubble); end
            n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_vld got=%b exp=1", id_valid); end
            n_checks++; if (state !== ((c == 0) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL stall_state got=%0d cyc=%0d", state, c); end
            tick();
        end
        stall_req = 1'b0; miss = 1'b0;
        @(negedge clk);
        n_checks++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=4", stall_cnt); end
        n_checks++; if (stage_stall !== 3'b000 || if_stall !== 1'b0 || id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b/%b/%b exp=000/0/1", stage_stall, if_stall, id_valid); end
        tick();
    endtask

    task automatic test_stall_vs_mispredict();
        stall_req = 1'b1; mp = 1'b1; mp_pc = 32'h1234_5678;
        tick();
        mp = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL svm_state got=%0d exp=2", state); end
        n_checks++; if (stage_stall !== 3'b000 || if_stall !== 1'b0 || if_redirect !== 1'b1) begin n_fail++; $display("FAIL svm_ctl got=%b/%b/%b exp=000/0/1", stage_stall, if_stall, if_redirect); end
        tick();
        @(negedge clk);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL svm_after got=%0d exp=0", state); end
        n_checks++; if (stall_cnt !== 16'(sat(m_stall_ev, 65535))) begin n_fail++; $display("FAIL svm_stall_cnt got=%0d exp=%0d", stall_cnt, m_stall_ev); end
        stall_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = m_flush_ev;
        mp = 1'b1; mp_pc = 32'h0000_0100;
        tick();
        @(negedge clk);
        n_checks++; if (state !== 2'd2 || if_rpc !== 32'h100) begin n_fail++; $display("FAIL b2b_first got=%0d/%h exp=2/100", state, if_rpc); end
        mp_pc = 32'h0000_0200;
        tick();
        mp = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 2'd2 || if_rpc !== 32'h200) begin n_fail++; $display("FAIL b2b_second got=%0d/%h exp=2/200", state, if_rpc); end
        n_checks++; if (flush_cnt !== 16'(f0 + 2)) begin n_fail++; $display("FAIL b2b_flush_cnt got=%0d exp=%0d", flush_cnt, f0 + 2); end
        tick();
        @(negedge clk);
        n_checks++; if (state !== 2'd0 || if_redirect !== 1'b0 || if_rpc !== 32'h200) begin n_fail++; $display("FAIL b2b_exit got=%0d/%b/%h exp=0/0/200", state, if_redirect, if_rpc); end
    endtask

    task automatic test_saturation_and_reset();
        stall_req = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        @(negedge clk);
        n_checks++; if (s_scnt !== 3'd7) begin n_fail++; $display("FAIL sat_small got=%0d exp=7", s_scnt); end
        n_checks++; if (stall_cnt !== 16'(sat(m_stall_ev, 65535))) begin n_fail++; $display("FAIL sat_main got=%0d exp=%0d", stall_cnt, m_stall_ev); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL sat_hold got=%0d exp=1", state); end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (state !== 2'd0 || stall_cnt !== 16'd0 || s_scnt !== 3'd0) begin n_fail++; $display("FAIL hold_rst got=%0d/%0d/%0d exp=0/0/0", state, stall_cnt, s_scnt); end
        n_checks++; if (stage_stall !== 3'b000 || if_stall !== 1'b1 || stage_bubble !== 3'b111) begin n_fail++; $display("FAIL hold_rst_out got=%b/%b/%b exp=000/1/111", stage_stall, if_stall, stage_bubble); end
        rst_n = 1'b1; stall_req = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (state !== 2'd0 || if_stall !== 1'b0 || stage_stall !== 3'b000) begin n_fail++; $display("FAIL hold_residual got=%0d/%b/%b exp=0/0/000", state, if_stall, stage_stall); end
        mp = 1'b1; mp_pc = 32'hCAFE_0000;
        tick();
        rst_n = 1'b0; mp = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (state !== 2'd0 || if_redirect !== 1'b0 || if_rpc !== 32'h0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_rst got=%0d/%b/%h/%0d exp=0/0/0/0", state, if_redirect, if_rpc, flush_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 39) != 0);
            stall_req = ($urandom_range(0, 2) == 0);
            miss      = ($urandom_range(0, 3) == 0);
            mp        = ($urandom_range(0, 6) == 0);
            mp_pc     = $urandom;
            @(negedge clk);
            model_comb();
            n_checks++; if (stage_stall !== e_stall || stage_bubble !== e_bub) begin n_fail++; $display("FAIL rnd_stage cyc=%0d got=%b/%b exp=%b/%b", c, stage_stall, stage_bubble, e_stall, e_bub); end
            n_checks++; if (if_stall !== e_ifs || if_redirect !== e_red) begin n_fail++; $display("FAIL rnd_if cyc=%0d got=%b/%b exp=%b/%b", c, if_stall, if_redirect, e_ifs, e_red); end
            n_checks++; if (state !== 2'(m_state) || id_valid !== e_idv3 || if_rpc !== m_pc) begin n_fail++; $display("FAIL rnd_state cyc=%0d got=%0d/%b/%h exp=%0d/%b/%h", c, state, id_valid, if_rpc, m_state, e_idv3, m_pc); end
            n_checks++; if (stall_cnt !== 16'(sat(m_stall_ev, 65535)) || flush_cnt !== 16'(sat(m_flush_ev, 65535))) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, m_stall_ev, m_flush_ev); end
            n_checks++; if (s_stall !== e_stall8 || s_bub !== e_bub8 || s_ifs !== e_ifs || s_red !== e_red) begin n_fail++; $display("FAIL rnd_deep_ctl cyc=%0d got=%b/%b exp=%b/%b", c, s_stall, s_bub, e_stall8, e_bub8); end
            n_checks++; if (s_idv !== e_idv8 || s_state !== 2'(m_state) || s_rpc !== m_pc) begin n_fail++; $display("FAIL rnd_deep_vld cyc=%0d got=%b/%0d exp=%b/%0d", c, s_idv, s_state, e_idv8, m_state); end
            n_checks++; if (s_scnt !== 3'(sat(m_stall_ev, 7)) || s_fcnt !== 3'(sat(m_flush_ev, 7))) begin n_fail++; $display("FAIL rnd_deep_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, s_scnt, s_fcnt, sat(m_stall_ev, 7), sat(m_flush_ev, 7)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_fill();
        test_mispredict();
        test_stall();
        test_stall_vs_mispredict();
        test_back_to_back();
        test_saturation_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
